ippcrc_crc32_stream: RTL and testbench

- Parametrised, pipelined CRC-32 engine over packet streams (Ethernet polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF).
- Generalises the fixed-width CRC step to any multiple-of-8 data width, with partial final beats and valid/ready flow control on both sides.
- Sits between the packet datapath and FCS insert/check logic; one result is produced per packet.

---
 rtl/ippcrc_pkg.sv | 29 ++
 rtl/ippcrc_crc32_byte.sv | 13 +
 rtl/ippcrc_crc32_stream.sv | 147 ++++++++++++++
 tb/tb_ippcrc_crc32_stream.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ippcrc_pkg.sv
// Shared constants and types for the streaming CRC-32 engine.
// Reflected Ethernet CRC-32: init and final XOR are all ones.
package ippcrc_pkg;

   localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   // One byte, LSB first, through the reflected register.
   function automatic logic [31:0] crc32_step(
      input logic [31:0] crc,
      input logic [7:0]  dat
   );
      logic [31:0] c;
      c = crc ^ {24'h0, dat};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/ippcrc_crc32_byte.sv
// Combinational single-byte CRC-32 step (reflected form).
// Chained once per byte lane by the stream engine.
module ippcrc_crc32_byte
   import ippcrc_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  dat,
   output logic [31:0] crc_nxt
);

   assign crc_nxt = crc32_step(crc, dat);

endmodule

// File: rtl/ippcrc_crc32_stream.sv
// Pipelined CRC-32 over a valid/ready packet stream, one result per packet.
// Define IPPCRC_STREAM_CHECK_EN to enable the crc_ok residue comparator.
module ippcrc_crc32_stream
   import ippcrc_pkg::*;
#(
   parameter int DW  = 64,
   parameter int NBW = (DW > 8) ? $clog2(DW / 8) : 1
)
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   output logic           in_rdy,
   input  logic           in_sop,
   input  logic           in_eop,
   input  logic [NBW-1:0] in_nbyte,
   input  logic [DW-1:0]  in_dat,
   output logic           crc_vld,
   input  logic           crc_rdy,
   output logic [31:0]    crc_val,
   output logic           crc_ok,
   output logic           sop_err
);

   localparam int NB = DW / 8;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] crc_q;
   logic [31:0] val_q;
   logic        err_q;
   logic [31:0] seed;
   logic [31:0] tap [NB+1];
   logic [31:0] fold;
   logic        acc;
   logic        load;
   logic        fin;
   logic        err_set;
   logic        err_clr;

   assign crc_vld = (state_q == DONE);
   assign in_rdy  = ~crc_vld | crc_rdy;
   assign acc     = in_vld & in_rdy;
   assign crc_val = val_q;
   assign sop_err = err_q;

   // A sop beat always starts from a fresh register, even mid-packet.
   assign seed   = in_sop ? CRC32_INIT : crc_q;
   assign tap[0] = seed;

   generate
      for (genvar g = 0; g < NB; g++) begin : g_byte
         ippcrc_crc32_byte u_byte (
            .crc     (tap[g]),
            .dat     (in_dat[DW-1-8*g -: 8]),
            .crc_nxt (tap[g+1])
         );
      end
   endgenerate

   // Tap after k bytes on a short eop beat; nbyte 0 means a full beat.
   always_comb begin
      fold = tap[NB];
      if (in_eop) begin
         for (int i = 1; i < NB; i++) begin
            if (in_nbyte == NBW'(i)) begin
               fold = tap[i];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      fin     = 1'b0;
      err_set = 1'b0;
      err_clr = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE && crc_rdy) begin
               state_d = IDLE;
            end
            if (acc) begin
               if (in_sop) begin
                  load    = 1'b1;
                  fin     = in_eop;
                  err_clr = 1'b1;
                  state_d = in_eop ? DONE : BUSY;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         BUSY: begin
            if (acc) begin
               load    = 1'b1;
               fin     = in_eop;
               err_clr = in_sop;
               if (in_eop) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= CRC32_INIT;
         val_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            crc_q <= fold;
         end
         if (fin) begin
            val_q <= ~fold;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end else if (err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

`ifdef IPPCRC_STREAM_CHECK_EN
   logic ok_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ok_q <= 1'b0;
      end else if (fin) begin
         ok_q <= (fold == CRC32_RESIDUE);
      end
   end

   assign crc_ok = ok_q;
`else
   assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_ippcrc_crc32_stream.sv
// Bench for ippcrc_crc32_stream at DW=32, 8 and 256 against a
// byte-stream CRC model with randomized valid and result-ready gaps.
module tb_ippcrc_crc32_stream;

   typedef logic [7:0] u8;
   typedef u8 bq_t[$];
   typedef logic [32:0] eq_t[$];

`ifdef IPPCRC_STREAM_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk;
   logic rst;
   logic [2:0] vld;
   logic [2:0] sop;
   logic [2:0] eop;
   logic [2:0] cr;
   logic [31:0] d0;
   logic [7:0] d1;
   logic [255:0] d2;
   logic [1:0] n0;
   logic n1;
   logic [4:0] n2;
   wire [2:0] rdy;
   wire [2:0] cv;
   wire [2:0] ok;
   wire [2:0] se;
   wire [2:0][31:0] val;

   int total = 0;
   int bad = 0;
   bit rnd_rdy[3];
   bit inpkt[3];
   bit err_exp[3];
   int acc_cnt[3];
   bq_t cur[3];
   eq_t expq[3];

   ippcrc_crc32_stream #(.DW(32)) u0 (
      .clk(clk), .rst(rst), .in_vld(vld[0]), .in_rdy(rdy[0]),
      .in_sop(sop[0]), .in_eop(eop[0]), .in_nbyte(n0), .in_dat(d0),
      .crc_vld(cv[0]), .crc_rdy(cr[0]), .crc_val(val[0]),
      .crc_ok(ok[0]), .sop_err(se[0])
   );

   ippcrc_crc32_stream #(.DW(8)) u1 (
      .clk(clk), .rst(rst), .in_vld(vld[1]), .in_rdy(rdy[1]),
      .in_sop(sop[1]), .in_eop(eop[1]), .in_nbyte(n1), .in_dat(d1),
      .crc_vld(cv[1]), .crc_rdy(cr[1]), .crc_val(val[1]),
      .crc_ok(ok[1]), .sop_err(se[1])
   );

   ippcrc_crc32_stream #(.DW(256)) u2 (
      .clk(clk), .rst(rst), .in_vld(vld[2]), .in_rdy(rdy[2]),
      .in_sop(sop[2]), .in_eop(eop[2]), .in_nbyte(n2), .in_dat(d2),
      .crc_vld(cv[2]), .crc_rdy(cr[2]), .crc_val(val[2]),
      .crc_ok(ok[2]), .sop_err(se[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Standard bit-serial definition over the whole message.
   function automatic logic [31:0] crc_ref(input bq_t m);
      logic [31:0] c;
      bit fb;
      c = 32'hFFFFFFFF;
      foreach (m[j]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ m[j][b];
            c = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   function automatic bit ok_ref(input logic [31:0] v);
      return CHK && (v == 32'h2144DF1C);
   endfunction

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int j = 0; j < s.len(); j++) q.push_back(u8'(s[j]));
      return q;
   endfunction

   function automatic int nbytes(input int i);
      return (i == 0) ? 4 : (i == 1) ? 1 : 32;
   endfunction

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   task automatic chk_reset(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_vld%0d", tag, i), 32'(cv[i]), 0);
         chk($sformatf("%s_val%0d", tag, i), val[i], 0);
         chk($sformatf("%s_ok%0d", tag, i), 32'(ok[i]), 0);
         chk($sformatf("%s_err%0d", tag, i), 32'(se[i]), 0);
         chk($sformatf("%s_rdy%0d", tag, i), 32'(rdy[i]), 1);
      end
   endtask

   task automatic drive(input int i, input logic [255:0] v, input bit s,
                        input bit e, input int nbv);
      case (i)
         0: begin d0 = v[255:224]; n0 = 2'(nbv); end
         1: begin d1 = v[255:248]; n1 = 1'(nbv); end
         default: begin d2 = v; n2 = 5'(nbv); end
      endcase
      sop[i] = s;
      eop[i] = e;
      vld[i] = 1'b1;
   endtask

   task automatic put_beat(input int i, input logic [255:0] v, input bit s,
                           input bit e, input int n, input int nbv);
      int t;
      bit got;
      logic [31:0] c;
      @(negedge clk);
      drive(i, v, s, e, nbv);
      t = 0;
      got = 1'b0;
      while (!got && t < 2000) begin
         #1;
         got = rdy[i];
         @(posedge clk);
         if (!got) begin
            @(negedge clk);
            t++;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL accept_timeout%0d: got no in_rdy want in_rdy", i);
         vld[i] = 1'b0;
         return;
      end
      acc_cnt[i]++;
      #1;
      vld[i] = 1'b0;
      if (s) begin
         cur[i].delete();
         inpkt[i] = 1'b1;
         err_exp[i] = 1'b0;
      end else if (!inpkt[i]) begin
         err_exp[i] = 1'b1;
         return;
      end
      for (int j = 0; j < n; j++) cur[i].push_back(v[255-8*j -: 8]);
      if (e) begin
         c = crc_ref(cur[i]);
         expq[i].push_back({ok_ref(c), c});
         inpkt[i] = 1'b0;
         chk($sformatf("lat_vld%0d", i), 32'(cv[i]), 1);
      end
   endtask

   task automatic send_pkt(input int i, input bq_t m, input bit s,
                           input bit e, input int gap);
      int nb;
      int nbeat;
      int n;
      int idx;
      bit last;
      bit ee;
      logic [255:0] v;
      nb = nbytes(i);
      nbeat = (m.size() + nb - 1) / nb;
      for (int b = 0; b < nbeat; b++) begin
         for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
         for (int j = 0; j < nb; j++) begin
            idx = b * nb + j;
            if (idx < m.size()) v[255-8*j -: 8] = m[idx];
         end
         last = (b == nbeat - 1);
         n = last ? (m.size() - b * nb) : nb;
         ee = e && last;
         repeat ($urandom_range(0, gap)) @(negedge clk);
         put_beat(i, v, s && (b == 0), ee, n,
                  ee ? ((n == nb) ? 0 : n) : int'($urandom()));
      end
   endtask

   task automatic run_rand(input int i);
      bq_t m;
      int len;
      int nb;
      nb = nbytes(i);
      for (int p = 0; p < 12; p++) begin
         len = (p == 0) ? 1 : (p == 1) ? nb : (p == 2) ? nb + 1
             : int'($urandom_range(1, 300));
         m.delete();
         for (int j = 0; j < len; j++) m.push_back(u8'($urandom()));
         send_pkt(i, m, 1'b1, 1'b1, 2);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rnd_rdy[i]) cr[i] = ($urandom_range(0, 3) != 0);
      end
   end

   // Compare process: sticky error every cycle, result while valid.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("sop_err%0d", i), 32'(se[i]), 32'(err_exp[i]));
            if (cv[i]) begin
               if (expq[i].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_vld%0d: got crc_vld=1 want 0", i);
               end else begin
                  chk($sformatf("crc_val%0d", i), val[i], expq[i][0][31:0]);
                  chk($sformatf("crc_ok%0d", i), 32'(ok[i]),
                      32'(expq[i][0][32]));
                  if (cr[i]) void'(expq[i].pop_front());
               end
            end
         end
      end
   end

   initial begin
      bq_t m;
      bq_t f;
      int saved;
      int t;
      logic [31:0] held;
      rst = 1'b1;
      vld = '0;
      sop = '0;
      eop = '0;
      cr = 3'b111;
      d0 = '0;
      d1 = '0;
      d2 = '0;
      n0 = '0;
      n1 = '0;
      n2 = '0;
      for (int i = 0; i < 3; i++) begin
         rnd_rdy[i] = 1'b0;
         inpkt[i] = 1'b0;
         err_exp[i] = 1'b0;
         acc_cnt[i] = 0;
      end
      #1;
      chk_reset("por");
      m = s2q("123456789");
      chk("ref_check", crc_ref(m), 32'hCBF43926);
      f = m;
      f.push_back(8'h26);
      f.push_back(8'h39);
      f.push_back(8'hF4);
      f.push_back(8'hCB);
      chk("ref_residue", crc_ref(f), 32'h2144DF1C);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", 32'(rdy[0]), 1);

      send_pkt(0, m, 1'b1, 1'b1, 0);
      chk("check_val", val[0], 32'hCBF43926);

      send_pkt(0, f, 1'b1, 1'b1, 1);
      chk("fcs_val", val[0], 32'h2144DF1C);
      chk("fcs_ok", 32'(ok[0]), 32'(CHK));
      f[4] = f[4] ^ 8'h01;
      send_pkt(0, f, 1'b1, 1'b1, 0);
      chk("flip_ok", 32'(ok[0]), 0);
      chk("flip_val", val[0], crc_ref(f));

      @(posedge clk);
      @(negedge clk);
      cr[0] = 1'b0;
      send_pkt(0, s2q("ABCDEFG"), 1'b1, 1'b1, 0);
      held = crc_ref(s2q("ABCDEFG"));
      saved = acc_cnt[0];
      fork
         send_pkt(0, m, 1'b1, 1'b1, 0);
         begin
            repeat (5) begin
               @(negedge clk);
               #1;
               chk("stall_rdy", 32'(rdy[0]), 0);
               chk("stall_val", val[0], held);
               chk("stall_cnt", 32'(acc_cnt[0]), 32'(saved));
            end
            @(negedge clk);
            cr[0] = 1'b1;
            #1;
            chk("release_rdy", 32'(rdy[0]), 1);
            chk("release_vld", 32'(cv[0]), 1);
            @(posedge clk);
            #1;
            chk("release_acc", 32'(acc_cnt[0]), 32'(saved + 1));
         end
      join
      chk("after_stall_val", val[0], 32'hCBF43926);

      send_pkt(0, s2q("zz"), 1'b0, 1'b1, 0);
      @(negedge clk);
      #1;
      chk("stray_err", 32'(se[0]), 1);
      chk("stray_vld", 32'(cv[0]), 0);
      send_pkt(0, m, 1'b1, 1'b1, 0);
      chk("recover_val", val[0], 32'hCBF43926);
      @(negedge clk);
      #1;
      chk("recover_err", 32'(se[0]), 0);

      send_pkt(0, s2q("AB"), 1'b1, 1'b0, 0);
      send_pkt(0, m, 1'b1, 1'b1, 0);
      chk("restart_val", val[0], 32'hCBF43926);

      send_pkt(0, s2q("ABCDEFGH"), 1'b1, 1'b0, 0);
      send_pkt(0, s2q("zz"), 1'b0, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cur[i].delete();
         inpkt[i] = 1'b0;
         err_exp[i] = 1'b0;
         expq[i].delete();
      end
      #1;
      chk_reset("mid_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 3; i++) rnd_rdy[i] = 1'b1;
      fork
         run_rand(0);
         run_rand(1);
         run_rand(2);
      join

      t = 0;
      while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0
             && t < 500) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain%0d", i), 32'(expq[i].size()), 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
